// File: rtl/bcd_sevenseg_scan.sv
// bcd_sevenseg_scan
//   Time-multiplexed driver for NUM_DIGITS common-segment 7-segment digits.
//   A packed BCD word and per-digit decimal points are captured into a shadow
//   register. They are promoted to the displayed (active) register only at a
//   frame boundary, so one scan frame never mixes old and new digits. The
//   driver also does leading-zero blanking, shows a dash for non-BCD nibbles,
//   and keeps every anode off for one cycle at the start of each slot so the
//   previous digit's segments do not ghost onto the next digit.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   bcd_in     packed BCD word, nibble i = digit i (digit 0 least significant)
//   dp_in      decimal point per digit, 1 = lit
//   load       capture bcd_in/dp_in this cycle
//   blank_lz   1 = blank leading zeros (used live, not captured)
//   seg        {a,b,c,d,e,f,g}, a = bit 6 (inverted when SEG_ACT_LOW)
//   dp         decimal point of the active digit (inverted when SEG_ACT_LOW)
//   an         one-hot digit enable (inverted when AN_ACT_LOW)
//   digit_idx  current scan slot
//   err        the last load held a nibble > 9

// Per-digit decoder: BCD -> segments, with dash for invalid codes and a
// blank override that also kills the decimal point.
module bcd_sevenseg_digit (
  input  logic [3:0] nib,
  input  logic       dp_in,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       dp
);
  always_comb begin
    seg = 7'b0000001;
    case (nib)
      4'd0:    seg = 7'b1111110;
      4'd1:    seg = 7'b0110000;
      4'd2:    seg = 7'b1101101;
      4'd3:    seg = 7'b1111001;
      4'd4:    seg = 7'b0110011;
      4'd5:    seg = 7'b1011011;
      4'd6:    seg = 7'b1011111;
      4'd7:    seg = 7'b1110000;
      4'd8:    seg = 7'b1111111;
      4'd9:    seg = 7'b1111011;
      default: seg = 7'b0000001;
    endcase
    dp = dp_in;
    if (blank) begin
      seg = 7'b0000000;
      dp  = 1'b0;
    end
  end
endmodule

module bcd_sevenseg_scan #(
  parameter  int NUM_DIGITS  = 4,
  parameter  int REFRESH_DIV = 1000,
  parameter  int SEG_ACT_LOW = 0,
  parameter  int AN_ACT_LOW  = 0,
  localparam int IW          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IW-1:0]           digit_idx,
  output logic                    err
);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0]                presc;
  logic [NUM_DIGITS-1:0][3:0]   nib_in, shadow_bcd, act_bcd;
  logic [NUM_DIGITS-1:0]        shadow_dp, act_dp;
  logic                         pending;
  logic [NUM_DIGITS-1:0]        nib_bad, nib_zero, lane_blank, lane_dp;
  logic [NUM_DIGITS-1:0][6:0]   lane_seg;
  logic                         tc, last_slot, frame_end;
  logic [6:0]                   seg_q, seg_nxt;
  logic                         dp_q, dp_nxt;
  logic [NUM_DIGITS-1:0]        an_q, an_nxt;

  assign nib_in    = bcd_in;
  assign tc        = (presc == PW'(REFRESH_DIV - 1));
  assign last_slot = (digit_idx == IW'(NUM_DIGITS - 1));
  assign frame_end = tc & last_slot;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lane
    assign nib_bad[i]  = (nib_in[i] > 4'd9);
    // invalid nibbles are non-zero here, so they stop blanking
    assign nib_zero[i] = (act_bcd[i] == 4'd0);
    if (i == 0) begin : g_lsd
      assign lane_blank[i] = 1'b0;
    end else begin : g_upper
      // blank only when this digit and everything above it is zero
      assign lane_blank[i] = blank_lz & (&nib_zero[NUM_DIGITS-1:i]);
    end
    bcd_sevenseg_digit u_digit (
      .nib   (act_bcd[i]),
      .dp_in (act_dp[i]),
      .blank (lane_blank[i]),
      .seg   (lane_seg[i]),
      .dp    (lane_dp[i])
    );
  end

  // slot mux; anodes stay dark on prescaler 0 to hide the segment switch
  always_comb begin
    seg_nxt = '0;
    dp_nxt  = 1'b0;
    an_nxt  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IW'(i)) begin
        seg_nxt   = lane_seg[i];
        dp_nxt    = lane_dp[i];
        an_nxt[i] = (presc != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      digit_idx  <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      act_bcd    <= '0;
      act_dp     <= '0;
      pending    <= 1'b0;
      err        <= 1'b0;
      seg_q      <= '0;
      dp_q       <= 1'b0;
      an_q       <= '0;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc)
        digit_idx <= last_slot ? '0 : digit_idx + 1'b1;

      if (load) begin
        shadow_bcd <= nib_in;
        shadow_dp  <= dp_in;
        err        <= |nib_bad;
      end

      // a load on the boundary bypasses the shadow and wins over pending
      if (frame_end) begin
        if (load) begin
          act_bcd <= nib_in;
          act_dp  <= dp_in;
        end else if (pending) begin
          act_bcd <= shadow_bcd;
          act_dp  <= shadow_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end

      seg_q <= seg_nxt;
      dp_q  <= dp_nxt;
      an_q  <= an_nxt;
    end
  end

  assign seg = (SEG_ACT_LOW != 0) ? ~seg_q : seg_q;
  assign dp  = (SEG_ACT_LOW != 0) ? ~dp_q  : dp_q;
  assign an  = (AN_ACT_LOW  != 0) ? ~an_q  : an_q;

endmodule
